// File: rtl/i2c_target_byte_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned BIT_CNT_W = 4;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/i2c_target_byte_line_cond.sv
// Line conditioner: 2-FF synchronizer, optional glitch filter, edge detection.
// Optional filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_cond #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic level,
  output logic rise,
  output logic fall
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("i2c_line_cond: FILTER_LEN must be in 2..15");
  end

  logic [1:0] sync;
  logic       cond;
  logic       hist;

  // Reset to the idle-bus level so leaving reset never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '1;
    else       sync <= {sync[0], pad_i};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == cond) begin
      cnt <= '0;
    end else if (cnt == 4'(FILTER_LEN - 1)) begin
      cond <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
`else
  assign cond = sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= 1'b1;
    else       hist <= cond;
  end

  assign level = cond;
  assign rise  = cond & ~hist;
  assign fall  = ~cond & hist;

endmodule

// File: rtl/i2c_target_byte.sv
// I2C target responder: address match, byte writes to user logic, byte reads from user logic.
// Optional input glitch filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_byte
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADR    = 7'h50,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       tx_req,
  input  logic [7:0] tx_dat,
  output logic       addressed,
  output logic       rw,
  output logic       nack_rcvd
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk   (clk),
    .reset (reset),
    .pad_i (scl_pad_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk   (clk),
    .reset (reset),
    .pad_i (sda_pad_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_t state;
  bit_cnt_t   bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shift_in;
  logic       start_det;
  logic       stop_det;

  assign shift_in  = {shreg[6:0], sda_lvl};
  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign sda_pad_o = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      sda_padoen_o <= 1'b1;
      rx_dat       <= '0;
      rx_vld       <= 1'b0;
      tx_req       <= 1'b0;
      addressed    <= 1'b0;
      rw           <= 1'b0;
      nack_rcvd    <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      tx_req    <= 1'b0;
      nack_rcvd <= 1'b0;
      if (start_det) begin
        state        <= ADDR;
        bit_cnt      <= '0;
        sda_padoen_o <= 1'b1;
        addressed    <= 1'b0;
      end else if (stop_det) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        sda_padoen_o <= 1'b1;
        addressed    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shreg <= shift_in;
            if (bit_cnt == bit_cnt_t'(7)) begin
              bit_cnt <= '0;
              if (shift_in[7:1] == DEV_ADR) begin
                state <= ADDR_ACK;
                rw    <= shift_in[0];
              end else begin
                state <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + bit_cnt_t'(1);
            end
          end
          // bit_cnt 0: waiting for the fall that opens the ACK slot; 1: ACK driven
          ADDR_ACK: if (scl_fall) begin
            if (bit_cnt == '0) begin
              sda_padoen_o <= I2C_ACK;
              addressed    <= 1'b1;
              bit_cnt      <= bit_cnt_t'(1);
            end else begin
              sda_padoen_o <= 1'b1;
              bit_cnt      <= '0;
              state        <= WR_DATA;
            end
          end else if (scl_rise && bit_cnt == bit_cnt_t'(1) && rw) begin
            tx_req  <= 1'b1;
            bit_cnt <= '0;
            state   <= RD_DATA;
          end
          WR_DATA: if (scl_rise) begin
            shreg <= shift_in;
            if (bit_cnt == bit_cnt_t'(7)) begin
              rx_dat  <= shift_in;
              rx_vld  <= 1'b1;
              bit_cnt <= '0;
              state   <= WR_ACK;
            end else begin
              bit_cnt <= bit_cnt + bit_cnt_t'(1);
            end
          end
          WR_ACK: if (scl_fall) begin
            if (bit_cnt == '0) begin
              sda_padoen_o <= I2C_ACK;
              bit_cnt      <= bit_cnt_t'(1);
            end else begin
              sda_padoen_o <= 1'b1;
              bit_cnt      <= '0;
              state        <= WR_DATA;
            end
          end
          // bit_cnt counts bits already placed on SDA; 0 means load on this fall
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == '0) begin
              shreg        <= tx_dat;
              sda_padoen_o <= tx_dat[7];
              bit_cnt      <= bit_cnt_t'(1);
            end else if (bit_cnt == bit_cnt_t'(8)) begin
              sda_padoen_o <= 1'b1;
              bit_cnt      <= '0;
              state        <= RD_ACK;
            end else begin
              sda_padoen_o <= shreg[6];
              shreg        <= {shreg[6:0], 1'b0};
              bit_cnt      <= bit_cnt + bit_cnt_t'(1);
            end
          end
          RD_ACK: if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              tx_req <= 1'b1;
              state  <= RD_DATA;
            end else begin
              nack_rcvd <= 1'b1;
              addressed <= 1'b0;
              state     <= IGNORE;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_byte.sv
// Scoreboard bench for i2c_target_byte: bus-level master model, transaction-level expectations.
module tb_i2c_target_byte;

  localparam logic [6:0]  DEV_ADR = 7'h50;
  localparam int unsigned Q       = 25;  // clk cycles per SCL quarter period

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] rx_dat;
  logic       rx_vld, tx_req, addressed, rw, nack_rcvd;
  logic [7:0] tx_dat;

  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  always #4 clk = ~clk;

  i2c_target_byte #(.DEV_ADR(DEV_ADR), .FILTER_LEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .rx_dat       (rx_dat),
    .rx_vld       (rx_vld),
    .tx_req       (tx_req),
    .tx_dat       (tx_dat),
    .addressed    (addressed),
    .rw           (rw),
    .nack_rcvd    (nack_rcvd)
  );

  int checks = 0;
  int failures = 0;
  byte_q_t exp_rx_q;
  byte_q_t tx_q;
  int exp_nack = 0;
  int nack_seen = 0;
  int drive_cycles = 0;
  int sda_chg_high = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes, plays the user side of reads
  initial begin : monitor
    logic prev_oe, prev_scl;
    logic [7:0] e;
    tx_dat   = '0;
    prev_oe  = 1'b1;
    prev_scl = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!sda_padoen_o) drive_cycles++;
        if (scl_m && prev_scl && sda_padoen_o != prev_oe) sda_chg_high++;
        if (rx_vld) begin
          check("rx_vld_expected", exp_rx_q.size() != 0, 1);
          if (exp_rx_q.size() != 0) begin
            e = exp_rx_q.pop_front();
            check("rx_dat", rx_dat, e);
          end
        end
        if (tx_req) begin
          check("tx_req_expected", tx_q.size() != 0, 1);
          check("tx_req_rw", rw, 1);
          check("tx_req_addressed", addressed, 1);
          if (tx_q.size() != 0) tx_dat = tx_q.pop_front();
        end
        if (nack_rcvd) begin
          nack_seen++;
          check("nack_clears_addressed", addressed, 0);
        end
      end
      prev_oe  = sda_padoen_o;
      prev_scl = scl_m;
    end
  end

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(2 * Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  // SCL dips low for 2 clocks while high; the glitch filter must swallow it
  task automatic write_bit_glitch(input logic b);
    sda_m = b;    wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(2);
    scl_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    b = sda_bus;  wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(ack);
  endtask

  // Reference: a matching address ACKs every byte and delivers it; anything else is ignored
  task automatic do_write(input logic [6:0] adr, input byte_q_t data, input bit with_stop);
    bit   match;
    logic ack;
    match = (adr == DEV_ADR);
    i2c_start();
    write_byte({adr, 1'b0}, ack);
    check("wr_adr_ack", ack, match ? 1'b0 : 1'b1);
    check("wr_addressed", addressed, match);
    if (match) check("wr_rw", rw, 0);
    foreach (data[i]) begin
      if (match) exp_rx_q.push_back(data[i]);
      write_byte(data[i], ack);
      check("wr_data_ack", ack, match ? 1'b0 : 1'b1);
    end
    if (with_stop) begin
      i2c_stop();
      check("stop_clears_addressed", addressed, 0);
    end
  endtask

  // Reference: master ACKs every byte but the last; user bytes come back MSB first
  task automatic do_read(input logic [6:0] adr, input byte_q_t data);
    logic       ack;
    logic [7:0] got;
    foreach (data[i]) tx_q.push_back(data[i]);
    exp_nack++;
    i2c_start();
    write_byte({adr, 1'b1}, ack);
    check("rd_adr_ack", ack, 0);
    check("rd_rw", rw, 1);
    foreach (data[i]) begin
      read_byte(got, (i == data.size() - 1) ? 1'b1 : 1'b0);
      check("rd_data", got, data[i]);
    end
    check("nack_count", nack_seen, exp_nack);
    check("rd_nack_addressed", addressed, 0);
    i2c_stop();
  endtask

  initial begin : stim
    byte_q_t    d;
    logic       ack;
    logic [6:0] adr;
    int         base_drive;
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(5);
    check("rst_padoen", sda_padoen_o, 1);
    check("rst_pad_o", sda_pad_o, 0);
    check("rst_rx_dat", rx_dat, 0);
    check("rst_strobes", {rx_vld, tx_req, nack_rcvd}, 0);
    check("rst_addressed", addressed, 0);
    check("rst_rw", rw, 0);
    reset = 1'b0;
    wait_cyc(10);

    d = {8'hA5, 8'h3C};
    do_write(7'h50, d, 1'b1);

    base_drive = drive_cycles;
    d = {8'h77, 8'h00};
    do_write(7'h51, d, 1'b1);
    check("wrong_adr_never_drives", drive_cycles - base_drive, 0);

    d = {8'h96, 8'h01};
    do_read(7'h50, d);

    d = {8'h11};
    do_write(7'h50, d, 1'b0);
    d = {8'h5A};
    do_read(7'h50, d);
    check("rstart_rx_dat", rx_dat, 8'h11);

    // Reset while the address ACK is on the bus
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(8'hA0 >> i);
    check("ack_driven_before_reset", sda_padoen_o, 0);
    reset = 1'b1;
    #1;
    check("reset_releases_sda", sda_padoen_o, 1);
    check("reset_clears_addressed", addressed, 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4);
    i2c_stop();
    d = {8'hC3};
    do_write(7'h50, d, 1'b1);

    for (int k = 0; k < 6; k++) begin
      d = {};
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) d.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0: do_write(DEV_ADR, d, 1'b1);
        1: begin
          adr = 7'($urandom);
          if (adr == DEV_ADR) adr = adr ^ 7'h01;
          do_write(adr, d, 1'b1);
        end
        default: do_read(DEV_ADR, d);
      endcase
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    i2c_start();
    write_byte({DEV_ADR, 1'b0}, ack);
    check("glitch_adr_ack", ack, 0);
    exp_rx_q.push_back(8'h6B);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) write_bit_glitch(8'h6B >> i);
      else        write_bit(8'h6B >> i);
    end
    read_bit(ack);
    check("glitch_data_ack", ack, 0);
    i2c_stop();
`endif

    wait_cyc(20);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    check("nack_total", nack_seen, exp_nack);
    check("sda_change_while_scl_high", sda_chg_high, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
